sdram_access_arbiter: RTL and testbench

SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

---
 rtl/sdram_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_access_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter: three-way arbiter (refresh > QSPI read > USB write)
// in front of a single SDRAM controller command port.
// Optional feature macro: SDRAM_ARB_STARVE_GUARD_EN. When it is defined,
// the USB port is promoted above QSPI after STARVE_MAX consecutive QSPI
// wins that occur while USB is waiting.
module sdram_access_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 9,
    parameter int STARVE_MAX = 8
) (
    input  logic              sd_clk,
    input  logic              rst,
    input  logic              ref_req,
    output logic              ref_ack,
    input  logic              qrd_req,
    input  logic [ADDR_W-1:0] qrd_addr,
    input  logic [LEN_W-1:0]  qrd_len,
    output logic              qrd_gnt,
    output logic              qrd_done,
    input  logic              uwr_req,
    input  logic [ADDR_W-1:0] uwr_addr,
    input  logic [LEN_W-1:0]  uwr_len,
    output logic              uwr_gnt,
    output logic              uwr_done,
    output logic              ctl_cmd_valid,
    output logic [1:0]        ctl_cmd,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [LEN_W-1:0]  ctl_len,
    input  logic              ctl_cmd_ready,
    input  logic              ctl_done,
    output logic [1:0]        owner,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    // Source encoding doubles as the controller command and the owner code.
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_QRD  = 2'b01;
    localparam logic [1:0] SRC_UWR  = 2'b10;
    localparam logic [1:0] SRC_REF  = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        win_sel;
    logic              usb_force;
    logic              handshake;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign usb_force = (starve_q == CNT_W'(STARVE_MAX));

    // Starvation counter: count QSPI grants taken while USB waits, clear on USB grant.
    always_comb begin
        starve_d = starve_q;
        if (uwr_gnt) begin
            starve_d = '0;
        end else if (qrd_gnt && uwr_req && !usb_force) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict priority: USB never overtakes QSPI (STARVE_MAX has no effect here,
    // the comparison is a constant false).
    assign usb_force = (STARVE_MAX < 0);
`endif

    // Winner selection among the currently asserted requests.
    always_comb begin
        win_sel = SRC_NONE;
        if (ref_req) begin
            win_sel = SRC_REF;
        end else if (usb_force && uwr_req) begin
            win_sel = SRC_UWR;
        end else if (qrd_req) begin
            win_sel = SRC_QRD;
        end else if (uwr_req) begin
            win_sel = SRC_UWR;
        end
    end

    // State, winner and latched command registers.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= SRC_NONE;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic: latch the winner in IDLE, hand off in ISSUE, wait for completion.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        addr_d  = addr_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_sel != SRC_NONE) begin
                    state_d = ST_ISSUE;
                    win_d   = win_sel;
                    case (win_sel)
                        SRC_QRD: begin
                            addr_d = qrd_addr;
                            len_d  = qrd_len;
                        end
                        SRC_UWR: begin
                            addr_d = uwr_addr;
                            len_d  = uwr_len;
                        end
                        default: begin
                            addr_d = '0;
                            len_d  = '0;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (ctl_cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ctl_done) begin
                    state_d = ST_IDLE;
                    win_d   = SRC_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                win_d   = SRC_NONE;
            end
        endcase
    end

    // Outputs decoded from the current state and the registered winner.
    always_comb begin
        handshake     = (state_q == ST_ISSUE) && ctl_cmd_ready;
        ctl_cmd_valid = (state_q == ST_ISSUE);
        ctl_cmd       = (state_q == ST_ISSUE) ? win_q : 2'b00;
        ctl_addr      = addr_q;
        ctl_len       = len_q;
        ref_ack       = handshake && (win_q == SRC_REF);
        qrd_gnt       = handshake && (win_q == SRC_QRD);
        uwr_gnt       = handshake && (win_q == SRC_UWR);
        qrd_done      = (state_q == ST_WAIT) && ctl_done && (win_q == SRC_QRD);
        uwr_done      = (state_q == ST_WAIT) && ctl_done && (win_q == SRC_UWR);
        owner         = (state_q == ST_IDLE) ? SRC_NONE : win_q;
        busy          = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Testbench for sdram_access_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbiter.
module tb_sdram_access_arbiter;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 9;
    localparam int SMAX   = 8;

    logic              sd_clk = 1'b0;
    logic              rst;
    logic              ref_req, ref_ack;
    logic              qrd_req, qrd_gnt, qrd_done;
    logic [ADDR_W-1:0] qrd_addr;
    logic [LEN_W-1:0]  qrd_len;
    logic              uwr_req, uwr_gnt, uwr_done;
    logic [ADDR_W-1:0] uwr_addr;
    logic [LEN_W-1:0]  uwr_len;
    logic              ctl_cmd_valid, ctl_cmd_ready, ctl_done;
    logic [1:0]        ctl_cmd, owner;
    logic [ADDR_W-1:0] ctl_addr;
    logic [LEN_W-1:0]  ctl_len;
    logic              busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 sd_clk = ~sd_clk;

    sdram_access_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STARVE_MAX(SMAX)) dut (
        .sd_clk(sd_clk), .rst(rst),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .qrd_req(qrd_req), .qrd_addr(qrd_addr), .qrd_len(qrd_len),
        .qrd_gnt(qrd_gnt), .qrd_done(qrd_done),
        .uwr_req(uwr_req), .uwr_addr(uwr_addr), .uwr_len(uwr_len),
        .uwr_gnt(uwr_gnt), .uwr_done(uwr_done),
        .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr),
        .ctl_len(ctl_len), .ctl_cmd_ready(ctl_cmd_ready), .ctl_done(ctl_done),
        .owner(owner), .busy(busy)
    );

    task automatic tick;
        @(posedge sd_clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        ref_req = 0; qrd_req = 0; uwr_req = 0;
        qrd_addr = '0; qrd_len = '0; uwr_addr = '0; uwr_len = '0;
        ctl_cmd_ready = 0; ctl_done = 0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        #1;
        vectors++;
        if (busy !== 1'b0 || owner !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b owner=%b expected busy=0 owner=00", busy, owner);
        end
        vectors++;
        if (ctl_cmd_valid !== 1'b0 || ctl_cmd !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_cmd: valid=%b cmd=%b expected 0/00", ctl_cmd_valid, ctl_cmd);
        end
        vectors++;
        if (ctl_addr !== '0 || ctl_len !== '0) begin
            miscompares++;
            $display("FAIL reset_addr_len: addr=%h len=%h expected 0/0", ctl_addr, ctl_len);
        end
        vectors++;
        if ({ref_ack, qrd_gnt, uwr_gnt, qrd_done, uwr_done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b expected 00000",
                     {ref_ack, qrd_gnt, uwr_gnt, qrd_done, uwr_done});
        end
    endtask

    task automatic test_basic_read;
        apply_reset;
        qrd_req = 1; qrd_addr = 24'h000100; qrd_len = 9'd7; ctl_cmd_ready = 1;
        #1;
        vectors++;
        if (busy !== 1'b0 || ctl_cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: busy=%b valid=%b expected 0/0", busy, ctl_cmd_valid);
        end
        tick;
        vectors++;
        if (ctl_cmd_valid !== 1'b1 || ctl_cmd !== 2'b01 || ctl_addr !== 24'h000100 ||
            ctl_len !== 9'd7 || qrd_gnt !== 1'b1 || owner !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_issue: valid=%b cmd=%b addr=%h len=%0d gnt=%b owner=%b expected 1/01/000100/7/1/01",
                     ctl_cmd_valid, ctl_cmd, ctl_addr, ctl_len, qrd_gnt, owner);
        end
        tick;
        qrd_req = 0;
        #1;
        vectors++;
        if (ctl_cmd_valid !== 1'b0 || qrd_gnt !== 1'b0 || owner !== 2'b01 || qrd_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_wait: valid=%b gnt=%b owner=%b done=%b expected 0/0/01/0",
                     ctl_cmd_valid, qrd_gnt, owner, qrd_done);
        end
        ctl_done = 1;
        #1;
        vectors++;
        if (qrd_done !== 1'b1 || uwr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: qrd_done=%b uwr_done=%b expected 1/0", qrd_done, uwr_done);
        end
        tick;
        ctl_done = 0;
        #1;
        vectors++;
        if (owner !== 2'b00 || busy !== 1'b0 || qrd_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_return: owner=%b busy=%b done=%b expected 00/0/0", owner, busy, qrd_done);
        end
    endtask

    task automatic test_priority;
        logic [1:0] order [3];
        int n = 0;
        int gap_err = 0;
        bit idle_seen = 0;
        bit rdrop = 0, qdrop = 0, udrop = 0;
        apply_reset;
        order[0] = 2'b00; order[1] = 2'b00; order[2] = 2'b00;
        ref_req = 1; qrd_req = 1; uwr_req = 1; ctl_cmd_ready = 1;
        qrd_addr = 24'h0ABCDE; uwr_addr = 24'h123456; qrd_len = 9'd3; uwr_len = 9'd15;
        for (int c = 0; c < 60 && !(n >= 3 && !busy); c++) begin
            if (rdrop) begin ref_req = 0; rdrop = 0; end
            if (qdrop) begin qrd_req = 0; qdrop = 0; end
            if (udrop) begin uwr_req = 0; udrop = 0; end
            ctl_done = busy && !ctl_cmd_valid;
            #1;
            if (ctl_cmd_valid && ctl_cmd_ready) begin
                if (n < 3) order[n] = ctl_cmd;
                if (n > 0 && !idle_seen) gap_err++;
                idle_seen = 0;
                n++;
            end
            if (!busy) idle_seen = 1;
            if (ref_ack) rdrop = 1;
            if (qrd_gnt) qdrop = 1;
            if (uwr_gnt) udrop = 1;
            tick;
        end
        ctl_done = 0;
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL prio_count: %0d operations served, expected 3", n);
        end
        vectors++;
        if (order[0] !== 2'b11 || order[1] !== 2'b01 || order[2] !== 2'b10) begin
            miscompares++;
            $display("FAIL prio_order: got %b,%b,%b expected 11,01,10", order[0], order[1], order[2]);
        end
        vectors++;
        if (gap_err !== 0) begin
            miscompares++;
            $display("FAIL prio_gap: %0d back-to-back issues without an idle cycle, expected 0", gap_err);
        end
    endtask

    task automatic test_ready_stall;
        int bad_valid = 0, bad_addr = 0, bad_gnt = 0;
        logic [ADDR_W-1:0] a;
        logic [LEN_W-1:0]  l;
        apply_reset;
        a = ADDR_W'($urandom);
        l = LEN_W'($urandom);
        uwr_req = 1; uwr_addr = a; uwr_len = l; ctl_cmd_ready = 0;
        tick;
        for (int i = 0; i < 6; i++) begin
            ctl_cmd_ready = (i == 5);
            #1;
            if (ctl_cmd_valid !== 1'b1 || ctl_cmd !== 2'b10) bad_valid++;
            if (ctl_addr !== a || ctl_len !== l) bad_addr++;
            if (uwr_gnt !== (i == 5)) bad_gnt++;
            tick;
        end
        vectors++;
        if (bad_valid !== 0) begin
            miscompares++;
            $display("FAIL stall_valid: %0d cycles without valid write command, expected 0", bad_valid);
        end
        vectors++;
        if (bad_addr !== 0) begin
            miscompares++;
            $display("FAIL stall_addr: %0d cycles with unstable addr/len, expected 0", bad_addr);
        end
        vectors++;
        if (bad_gnt !== 0) begin
            miscompares++;
            $display("FAIL stall_gnt: %0d cycles with wrong uwr_gnt, expected 0", bad_gnt);
        end
        uwr_req = 0; uwr_addr = ~a; uwr_len = ~l; ctl_cmd_ready = 0;
        #1;
        vectors++;
        if (ctl_addr !== a || ctl_len !== l) begin
            miscompares++;
            $display("FAIL latched_copy: addr=%h len=%h expected %h/%h", ctl_addr, ctl_len, a, l);
        end
        ctl_done = 1;
        tick;
        ctl_done = 0;
    endtask

    task automatic test_reset_in_wait;
        apply_reset;
        uwr_req = 1; uwr_addr = 24'h00BEEF; uwr_len = 9'd1; ctl_cmd_ready = 1;
        tick;
        tick;
        uwr_req = 0;
        #1;
        vectors++;
        if (owner !== 2'b10 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_pre: owner=%b busy=%b expected 10/1", owner, busy);
        end
        rst = 1;
        tick;
        rst = 0;
        #1;
        vectors++;
        if (busy !== 1'b0 || owner !== 2'b00 || uwr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_post: busy=%b owner=%b done=%b expected 0/00/0", busy, owner, uwr_done);
        end
        ctl_done = 1;
        #1;
        vectors++;
        if (uwr_done !== 1'b0 || qrd_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_late_done: uwr_done=%b qrd_done=%b expected 0/0", uwr_done, qrd_done);
        end
        tick;
        ctl_done = 0;
    endtask

    task automatic test_done_in_idle;
        apply_reset;
        ctl_done = 1; ctl_cmd_ready = 1;
        #1;
        vectors++;
        if (qrd_done !== 1'b0 || uwr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done: qrd_done=%b uwr_done=%b expected 0/0", qrd_done, uwr_done);
        end
        tick;
        ctl_done = 0;
        #1;
        vectors++;
        if (busy !== 1'b0 || owner !== 2'b00 || ctl_cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_state: busy=%b owner=%b valid=%b expected 0/00/0", busy, owner, ctl_cmd_valid);
        end
    endtask

    task automatic test_starvation;
        int qg = 0, ug = 0;
        bit qdrop = 0;
        apply_reset;
        uwr_req = 1; uwr_addr = 24'h000777; uwr_len = 9'd2;
        qrd_req = 1; qrd_addr = 24'h000555; qrd_len = 9'd4; ctl_cmd_ready = 1;
        for (int c = 0; c < 300 && ug == 0 && qg < 12; c++) begin
            if (qdrop) begin qrd_req = 0; qdrop = 0; end
            else qrd_req = 1;
            ctl_done = busy && !ctl_cmd_valid;
            #1;
            if (qrd_gnt) begin qg++; qdrop = 1; end
            if (uwr_gnt) ug++;
            tick;
        end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        vectors++;
        if (ug !== 1 || qg !== SMAX) begin
            miscompares++;
            $display("FAIL starve_guard: uwr_gnt=%0d after %0d QSPI grants, expected 1 after %0d", ug, qg, SMAX);
        end
`else
        vectors++;
        if (ug !== 0 || qg !== 12) begin
            miscompares++;
            $display("FAIL strict_prio: uwr_gnt=%0d with %0d QSPI grants, expected 0 with 12", ug, qg);
        end
`endif
        qrd_req = 0; ctl_done = 0;
        apply_reset;
    endtask

    task automatic test_random;
        // model: current operation (source 0 = none), whether the controller took it
        int m_who = 0;
        bit m_taken = 0;
        logic [ADDR_W-1:0] m_addr = '0;
        logic [LEN_W-1:0]  m_len = '0;
        int m_starve = 0;
        bit rdrop = 0, qdrop = 0, udrop = 0;
        bit e_valid, e_busy, e_rack, e_qg, e_ug, e_qd, e_ud;
        apply_reset;
        for (int c = 0; c < 3000; c++) begin
            if (rdrop) begin ref_req = 0; rdrop = 0; end
            else if (!ref_req && $urandom_range(0, 19) == 0) ref_req = 1;
            if (qdrop) begin qrd_req = 0; qdrop = 0; end
            else if (!qrd_req && $urandom_range(0, 2) == 0) begin
                qrd_req = 1; qrd_addr = ADDR_W'($urandom); qrd_len = LEN_W'($urandom);
            end
            if (udrop) begin uwr_req = 0; udrop = 0; end
            else if (!uwr_req && $urandom_range(0, 2) == 0) begin
                uwr_req = 1; uwr_addr = ADDR_W'($urandom); uwr_len = LEN_W'($urandom);
            end
            ctl_cmd_ready = ($urandom_range(0, 2) != 0);
            ctl_done      = ($urandom_range(0, 2) == 0);
            #1;
            e_busy  = (m_who != 0);
            e_valid = e_busy && !m_taken;
            e_rack  = e_valid && ctl_cmd_ready && m_who == 3;
            e_qg    = e_valid && ctl_cmd_ready && m_who == 1;
            e_ug    = e_valid && ctl_cmd_ready && m_who == 2;
            e_qd    = m_taken && ctl_done && m_who == 1;
            e_ud    = m_taken && ctl_done && m_who == 2;
            vectors++;
            if (busy !== e_busy || ctl_cmd_valid !== e_valid || owner !== 2'(m_who)) begin
                miscompares++;
                $display("FAIL rnd_status c=%0d: busy=%b valid=%b owner=%b expected %b/%b/%b",
                         c, busy, ctl_cmd_valid, owner, e_busy, e_valid, 2'(m_who));
            end
            vectors++;
            if ({ref_ack, qrd_gnt, uwr_gnt, qrd_done, uwr_done} !== {e_rack, e_qg, e_ug, e_qd, e_ud}) begin
                miscompares++;
                $display("FAIL rnd_pulses c=%0d: ack/qg/ug/qd/ud=%b expected %b", c,
                         {ref_ack, qrd_gnt, uwr_gnt, qrd_done, uwr_done}, {e_rack, e_qg, e_ug, e_qd, e_ud});
            end
            if (e_busy) begin
                vectors++;
                if (ctl_addr !== m_addr || ctl_len !== m_len || (e_valid && ctl_cmd !== 2'(m_who))) begin
                    miscompares++;
                    $display("FAIL rnd_cmd c=%0d: cmd=%b addr=%h len=%h expected %b/%h/%h",
                             c, ctl_cmd, ctl_addr, ctl_len, 2'(m_who), m_addr, m_len);
                end
            end
            // advance the model to the next clock edge
            if (m_who == 0) begin
                m_taken = 0;
                if (ref_req) begin
                    m_who = 3; m_addr = '0; m_len = '0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
                end else if (uwr_req && m_starve >= SMAX) begin
                    m_who = 2; m_addr = uwr_addr; m_len = uwr_len;
`endif
                end else if (qrd_req) begin
                    m_who = 1; m_addr = qrd_addr; m_len = qrd_len;
                end else if (uwr_req) begin
                    m_who = 2; m_addr = uwr_addr; m_len = uwr_len;
                end
            end else if (!m_taken) begin
                if (ctl_cmd_ready) begin
                    m_taken = 1;
                    if (m_who == 3) rdrop = 1;
                    if (m_who == 1) begin
                        qdrop = 1;
                        if (uwr_req && m_starve < SMAX) m_starve++;
                    end
                    if (m_who == 2) begin
                        udrop = 1;
                        m_starve = 0;
                    end
                end
            end else if (ctl_done) begin
                m_who = 0;
                m_taken = 0;
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic_read;
        test_priority;
        test_ready_stall;
        test_reset_in_wait;
        test_done_in_idle;
        test_starvation;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
